// File: rtl/mem_access_ctrl_if.sv
// Data-cache bus between the MEM-stage access controller (master) and the cache (slave).
interface mem_access_ctrl_if;
  logic        read;
  logic        write;
  logic [15:0] address;
  logic [15:0] wdata;
  logic [1:0]  byte_enable;  // bit1 = high byte, bit0 = low byte
  logic        resp;
  logic [15:0] rdata;

  modport master (
    output read, write, address, wdata, byte_enable,
    input  resp, rdata
  );

  modport slave (
    input  read, write, address, wdata, byte_enable,
    output resp, rdata
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// LC-3b MEM-stage data-memory access controller: LDB/LDW/LDI/STB/STW/STI over the cache handshake.
// Optional word-alignment trap enabled by defining MEM_ACCESS_ALIGN_CHECK_EN.
module mem_access_ctrl (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  input  logic [3:0]               opcode,
  input  logic [15:0]              address,
  input  logic [15:0]              store_data,
  mem_access_ctrl_if.master        dmem,
  output logic [15:0]              load_data,
  output logic                     stall,
  output logic                     misaligned
);

  typedef enum logic [1:0] {IDLE, PTR, ACC, DONE} state_t;

  state_t      state, state_nxt;
  logic        op_byte_q, op_store_q;
  logic [15:0] addr_q, data_q;
  logic        misaligned_q, mis_nxt;
  logic        mem_op, req_misaligned, ptr_misaligned;
  logic [7:0]  rd_byte;
  logic [15:0] rd_result;

  // Memory opcodes are exactly those with bit1 set, excluding the 11xx group.
  assign mem_op = req_valid && opcode[1] && (opcode[3:2] != 2'b11);

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
  assign req_misaligned = (opcode[3:2] != 2'b00) && address[0];
  assign ptr_misaligned = dmem.rdata[0];
`else
  assign req_misaligned = 1'b0;
  assign ptr_misaligned = 1'b0;
`endif

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_nxt = state;
    mis_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (mem_op) begin
          if (req_misaligned) begin
            state_nxt = DONE;
            mis_nxt   = 1'b1;
          end else if (opcode[3:2] == 2'b10) begin
            state_nxt = PTR;
          end else begin
            state_nxt = ACC;
          end
        end
      end
      PTR: begin
        if (dmem.resp) begin
          if (ptr_misaligned) begin
            state_nxt = DONE;
            mis_nxt   = 1'b1;
          end else begin
            state_nxt = ACC;
          end
        end
      end
      ACC:     if (dmem.resp) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bus requests come only from registered state and latched operands.
  always_comb begin
    dmem.read        = 1'b0;
    dmem.write       = 1'b0;
    dmem.address     = 16'h0000;
    dmem.wdata       = 16'h0000;
    dmem.byte_enable = 2'b00;
    case (state)
      PTR: begin
        dmem.read        = 1'b1;
        dmem.address     = {addr_q[15:1], 1'b0};
        dmem.byte_enable = 2'b11;
      end
      ACC: begin
        dmem.read  = !op_store_q;
        dmem.write = op_store_q;
        if (op_byte_q) begin
          dmem.address     = addr_q;
          dmem.byte_enable = addr_q[0] ? 2'b10 : 2'b01;
        end else begin
          dmem.address     = {addr_q[15:1], 1'b0};
          dmem.byte_enable = 2'b11;
        end
        if (op_store_q)
          dmem.wdata = op_byte_q ? {data_q[7:0], data_q[7:0]} : data_q;
      end
      default: ;
    endcase
  end

  assign rd_byte   = addr_q[0] ? dmem.rdata[15:8] : dmem.rdata[7:0];
  assign rd_result = op_byte_q ? {{8{rd_byte[7]}}, rd_byte} : dmem.rdata;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      op_byte_q    <= 1'b0;
      op_store_q   <= 1'b0;
      addr_q       <= 16'h0000;
      data_q       <= 16'h0000;
      load_data    <= 16'h0000;
      misaligned_q <= 1'b0;
    end else begin
      state        <= state_nxt;
      misaligned_q <= mis_nxt;
      if (state == IDLE && mem_op) begin
        op_byte_q  <= (opcode[3:2] == 2'b00);
        op_store_q <= opcode[0];
        addr_q     <= address;
        data_q     <= store_data;
      end
      // The fetched pointer replaces the effective address for the second access.
      if (state == PTR && dmem.resp)
        addr_q <= dmem.rdata;
      if (state == ACC && dmem.resp && !op_store_q)
        load_data <= rd_result;
    end
  end

  assign stall      = (state == IDLE && mem_op) || (state == PTR) || (state == ACC);
  assign misaligned = misaligned_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed cases then random ops against a transaction-level model.
module tb_mem_access_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [3:0]  opcode;
  logic [15:0] address, store_data;
  logic [15:0] load_data;
  logic        stall, misaligned;

  int          total = 0;
  int          bad   = 0;
  logic [15:0] exp_load = 16'h0000;

  logic [3:0] op_tab [10] = '{4'b0010, 4'b0110, 4'b1010, 4'b0011, 4'b0111,
                              4'b1011, 4'b0001, 4'b1110, 4'b1111, 4'b0000};

  mem_access_ctrl_if dmem();

  mem_access_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .opcode     (opcode),
    .address    (address),
    .store_data (store_data),
    .dmem       (dmem),
    .load_data  (load_data),
    .stall      (stall),
    .misaligned (misaligned)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One bus access lasting waits+1 cycles; the response arrives on the last one.
  task automatic access(input logic rd, input logic wr, input logic [15:0] a,
                        input logic [1:0] be, input logic [15:0] wd, input int waits,
                        input logic [15:0] data, inout int n_stall);
    for (int w = 0; w <= waits; w++) begin
      @(posedge clk); #1;
      check("acc_rw", {dmem.read, dmem.write}, {rd, wr});
      check("acc_addr", dmem.address, a);
      check("acc_be", dmem.byte_enable, be);
      if (wr) check("acc_wdata", dmem.wdata, wd);
      check("acc_stall", stall, 1);
      n_stall += int'(stall);
      dmem.resp  = (w == waits);
      dmem.rdata = (w == waits) ? data : 16'($urandom);
    end
  endtask

  task automatic finish_op(input logic mis, inout int n_stall);
    @(posedge clk); #1;
    req_valid  = 1'b0;
    dmem.resp  = 1'($urandom);
    dmem.rdata = 16'($urandom);
    check("done_stall", stall, 0);
    n_stall += int'(stall);
    check("done_bus", {dmem.read, dmem.write, dmem.byte_enable, dmem.address, dmem.wdata}, 0);
    check("load_data", load_data, exp_load);
    check("done_misaligned", misaligned, mis);
    @(posedge clk); #1;
    dmem.resp = 1'b0;
    check("idle_misaligned", misaligned, 0);
  endtask

  // Issues one instruction from IDLE and returns in IDLE; ptr/rdata are the cache answers.
  task automatic run_op(input logic [3:0] opc, input logic [15:0] addr, input logic [15:0] sd,
                        input logic [15:0] ptr, input logic [15:0] rdata, input int w1, input int w2);
    logic        mem, bytop, ind, st, mis1, mis2;
    logic [15:0] a2;
    logic [7:0]  sel;
    int          n_stall, exp_stall;
    n_stall = 0;
    mem   = opc inside {4'b0010, 4'b0110, 4'b1010, 4'b0011, 4'b0111, 4'b1011};
    bytop = (opc[3:2] == 2'b00);
    ind   = (opc[3:2] == 2'b10);
    st    = opc[0];
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    mis1 = mem && !bytop && addr[0];
    mis2 = ind && ptr[0];
`else
    mis1 = 1'b0;
    mis2 = 1'b0;
`endif
    req_valid  = 1'b1;
    opcode     = opc;
    address    = addr;
    store_data = sd;
    dmem.resp  = 1'($urandom);
    dmem.rdata = 16'($urandom);
    #1;
    check("idle_stall", stall, mem);
    n_stall += int'(stall);
    check("idle_bus", {dmem.read, dmem.write}, 0);
    if (!mem) begin
      @(posedge clk); #1;
      check("nonmem_stall", stall, 0);
      check("nonmem_bus", {dmem.read, dmem.write}, 0);
      req_valid = 1'b0;
      dmem.resp = 1'b0;
      return;
    end
    exp_stall = 1;
    if (!mis1) begin
      if (ind) begin
        access(1'b1, 1'b0, {addr[15:1], 1'b0}, 2'b11, 16'h0000, w1, ptr, n_stall);
        exp_stall += w1 + 1;
        a2 = ptr;
      end else begin
        a2 = addr;
      end
      if (!mis2) begin
        access(!st, st, bytop ? a2 : {a2[15:1], 1'b0},
               bytop ? (a2[0] ? 2'b10 : 2'b01) : 2'b11,
               bytop ? {sd[7:0], sd[7:0]} : sd, w2, rdata, n_stall);
        exp_stall += w2 + 1;
        if (!st) begin
          if (bytop) begin
            sel      = a2[0] ? rdata[15:8] : rdata[7:0];
            exp_load = (sel >= 8'd128) ? 16'hFF00 + {8'h00, sel} : {8'h00, sel};
          end else begin
            exp_load = rdata;
          end
        end
      end
    end
    finish_op(mis1 || mis2, n_stall);
    check("stall_cycles", n_stall, exp_stall);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; opcode = 4'h0; address = 16'h0; store_data = 16'h0;
    dmem.resp = 1'b0; dmem.rdata = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_stall", stall, 0);
    check("rst_bus", {dmem.read, dmem.write, dmem.byte_enable, dmem.address, dmem.wdata}, 0);
    check("rst_load", load_data, 0);
    check("rst_misaligned", misaligned, 0);
    reset = 1'b0;

    run_op(4'b0010, 16'h3001, 16'h0000, 16'h0000, 16'h80FF, 0, 2);  // LDB, 2 waits
    check("ldb_result", load_data, 16'hFF80);
    run_op(4'b0011, 16'h2000, 16'h12AB, 16'h0000, 16'h0000, 0, 0);  // STB
    run_op(4'b1010, 16'h4000, 16'h0000, 16'h5002, 16'hBEEF, 0, 0);  // LDI
    check("ldi_result", load_data, 16'hBEEF);
    run_op(4'b0111, 16'h1235, 16'h55AA, 16'h0000, 16'h0000, 0, 1);  // STW odd address
    check("stw_load_held", load_data, 16'hBEEF);
    run_op(4'b0001, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 0, 0);  // ADD
    run_op(4'b0110, 16'h0010, 16'h0000, 16'h0000, 16'h1111, 0, 0);  // back-to-back LDW
    run_op(4'b0110, 16'h0020, 16'h0000, 16'h0000, 16'h2222, 0, 0);
    check("ldw2_result", load_data, 16'h2222);

    // Reset mid-access abandons it and discards the response
    req_valid = 1'b1; opcode = 4'b0110; address = 16'h0100;
    #1;
    check("rstacc_idle_stall", stall, 1);
    @(posedge clk); #1;
    check("rstacc_read", dmem.read, 1);
    reset = 1'b1; req_valid = 1'b0; dmem.resp = 1'b1; dmem.rdata = 16'hDEAD;
    @(posedge clk); #1;
    reset = 1'b0; dmem.resp = 1'b0;
    check("rstacc_read_dropped", dmem.read, 0);
    check("rstacc_stall", stall, 0);
    check("rstacc_load", load_data, 16'h0000);
    exp_load = 16'h0000;

    for (int i = 0; i < 80; i++) begin
      run_op(op_tab[$urandom_range(0, 9)], 16'($urandom), 16'($urandom), 16'($urandom),
             16'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
